// File: rtl/text_console_if.sv
// Byte-stream handshake into the text console.
//   in_valid : source has a byte on in_data
//   in_data  : ASCII byte
//   in_ready : console accepts the byte this cycle (in_valid && in_ready)
// master = byte source, slave = console.
interface text_console_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/text_console.sv
// Character-cell text terminal: a COLS x ROWS byte buffer fed by an ASCII
// stream (cursor, wrap, scroll, backspace, clear) and a combinational overlay
// pel generator driven by the font generator, with a blinking cursor.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_if (slave)         : in_valid / in_data / in_ready byte handshake
//   clear                 : level, full-screen clear with cursor home
//   vsync                 : frame sync, rising edges time the cursor blink
//   char_x, char_y        : font-generator character cell on screen
//   ascii_char            : font-generator pel bit for every code
//   out                   : overlay video bit
//   cur_col, cur_row      : cursor position
//   busy                  : FSM is in CLEAR or SCROLL
module text_console #(
  parameter int unsigned COLS         = 40,
  parameter int unsigned ROWS         = 16,
  parameter int unsigned X0           = 0,
  parameter int unsigned Y0           = 0,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  text_console_if.slave  in_if,
  input  logic           clear,
  input  logic           vsync,
  input  logic [7:0]     char_x,
  input  logic [7:0]     char_y,
  input  logic [255:0]   ascii_char,
  output logic           out,
  output logic [7:0]     cur_col,
  output logic [7:0]     cur_row,
  output logic           busy
);

  localparam int unsigned N  = COLS * ROWS;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned BW = $clog2(BLINK_FRAMES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_SCROLL = 2'd2;

  localparam logic [AW-1:0] LAST     = AW'(N - 1);
  localparam logic [AW-1:0] COPY_END = AW'(N - COLS);
  localparam logic [7:0]    COL_MAX  = 8'(COLS - 1);
  localparam logic [7:0]    ROW_MAX  = 8'(ROWS - 1);
  localparam logic [7:0]    SP       = 8'h20;
  localparam logic [8:0]    XLO      = 9'(X0);
  localparam logic [8:0]    XHI      = 9'(X0 + COLS - 1);
  localparam logic [8:0]    YLO      = 9'(Y0);
  localparam logic [8:0]    YHI      = 9'(Y0 + ROWS - 1);

  logic [7:0]    mem_q [N];
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    col_q, col_d;
  logic [7:0]    row_q, row_d;
  logic [BW:0]   blink_q;
  logic          vsync_q;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [AW-1:0] cur_addr;
  logic          accept;
  logic          nl;

  assign in_if.in_ready = (state_q == S_IDLE) && !clear;
  assign accept   = in_if.in_valid && in_if.in_ready;
  assign cur_addr = AW'(row_q) * AW'(COLS) + AW'(col_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    col_d   = col_q;
    row_d   = row_q;
    we      = 1'b0;
    waddr   = idx_q;
    wdata   = SP;
    nl      = 1'b0;

    case (state_q)
      S_CLEAR, S_SCROLL: begin
        // SCROLL shifts rows up cell by cell, then blanks the last row.
        we = 1'b1;
        if (state_q == S_SCROLL && idx_q < COPY_END) begin
          wdata = mem_q[idx_q + AW'(COLS)];
        end
        if (idx_q == LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
          if (state_q == S_CLEAR) begin
            col_d = '0;
            row_d = '0;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        if (accept) begin
          case (in_if.in_data)
            8'h0D: col_d = '0;
            8'h0A: begin
              col_d = '0;
              nl    = 1'b1;
            end
            8'h08: begin
              if (col_q != '0) begin
                col_d = col_q - 1'b1;
                we    = 1'b1;
                waddr = cur_addr - 1'b1;
              end
            end
            8'h0C: begin
              state_d = S_CLEAR;
              idx_d   = '0;
              col_d   = '0;
              row_d   = '0;
            end
            default: begin
              if (in_if.in_data >= 8'h20 && in_if.in_data <= 8'h7E) begin
                we    = 1'b1;
                waddr = cur_addr;
                wdata = in_if.in_data;
                if (col_q == COL_MAX) begin
                  col_d = '0;
                  nl    = 1'b1;
                end else begin
                  col_d = col_q + 1'b1;
                end
              end
            end
          endcase
          if (nl) begin
            if (row_q < ROW_MAX) begin
              row_d = row_q + 1'b1;
            end else begin
              state_d = S_SCROLL;
              idx_d   = '0;
            end
          end
        end
      end
    endcase

    // clear overrides everything, including a scroll in progress.
    if (clear) begin
      state_d = S_CLEAR;
      idx_d   = '0;
      col_d   = '0;
      row_d   = '0;
      we      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      vsync_q <= 1'b0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      row_q   <= row_d;
      vsync_q <= vsync;
      if (vsync && !vsync_q) begin
        blink_q <= blink_q + 1'b1;
      end
    end
  end

  // Buffer has no reset; CLEAR initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  logic [8:0]    cx, cy, dx, dy;
  logic          inwin, glyph, curs;
  logic [AW-1:0] rd_addr;
  logic [7:0]    code;

  always_comb begin
    cx      = {1'b0, char_x};
    cy      = {1'b0, char_y};
    dx      = cx - XLO;
    dy      = cy - YLO;
    inwin   = (cx >= XLO) && (cx <= XHI) && (cy >= YLO) && (cy <= YHI);
    rd_addr = inwin ? AW'(AW'(dy) * AW'(COLS) + AW'(dx)) : '0;
    code    = mem_q[rd_addr];
    glyph   = ascii_char[code];
    curs    = inwin && (dx == {1'b0, col_q}) && (dy == {1'b0, row_q}) &&
              blink_q[BW] && (state_q == S_IDLE);
    out     = inwin && (glyph ^ curs);
  end

  assign cur_col = col_q;
  assign cur_row = row_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_text_console.sv
module tb_text_console;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         clear1, clear2, vsync1, vsync2;
  logic [7:0]   char_x, char_y;
  logic [255:0] ascii_char;
  logic         out1, out2, busy1, busy2;
  logic [7:0]   col1, row1, col2, row2;

  always #5 clk = ~clk;

  text_console_if if1 ();
  text_console_if if2 ();

  text_console #(.COLS(40), .ROWS(16), .X0(0), .Y0(0), .BLINK_FRAMES(32)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_if(if1.slave), .clear(clear1),
    .vsync(vsync1), .char_x(char_x), .char_y(char_y), .ascii_char(ascii_char),
    .out(out1), .cur_col(col1), .cur_row(row1), .busy(busy1));

  text_console #(.COLS(40), .ROWS(16), .X0(10), .Y0(5), .BLINK_FRAMES(32)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_if(if2.slave), .clear(clear2),
    .vsync(vsync2), .char_x(char_x), .char_y(char_y), .ascii_char(ascii_char),
    .out(out2), .cur_col(col2), .cur_row(row2), .busy(busy2));

  int n_checks = 0;
  int n_err    = 0;
  logic exp_q[$];

  // Reference character buffer and cursor of dut1.
  logic [7:0] mbuf [640];
  int mcol, mrow;

  function automatic void model_clear();
    for (int i = 0; i < 640; i++) mbuf[i] = 8'h20;
    mcol = 0;
    mrow = 0;
  endfunction

  function automatic void model_nl();
    if (mrow < 15) mrow++;
    else begin
      for (int i = 0; i < 600; i++) mbuf[i] = mbuf[i+40];
      for (int i = 600; i < 640; i++) mbuf[i] = 8'h20;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      mbuf[mrow*40+mcol] = b;
      if (mcol == 39) begin mcol = 0; model_nl(); end
      else mcol++;
    end else if (b == 8'h0D) mcol = 0;
    else if (b == 8'h0A) begin mcol = 0; model_nl(); end
    else if (b == 8'h08) begin
      if (mcol > 0) begin mcol--; mbuf[mrow*40+mcol] = 8'h20; end
    end else if (b == 8'h0C) model_clear();
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic probe(input string tag, input bit which, input int x, input int y,
                       input logic [255:0] pat, input logic e);
    logic got;
    exp_q.push_back(e);
    char_x = 8'(x);
    char_y = 8'(y);
    ascii_char = pat;
    #1;
    got = which ? out2 : out1;
    check(tag, 32'(got), 32'(exp_q.pop_front()));
  endtask

  task automatic chk_cell(input int x, input int y);
    logic [255:0] oh;
    oh = '0;
    oh[mbuf[y*40+x]] = 1'b1;
    probe($sformatf("cell_hit(%0d,%0d)", x, y), 1'b0, x, y, oh, 1'b1);
    probe($sformatf("cell_miss(%0d,%0d)", x, y), 1'b0, x, y, ~oh, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    if1.in_valid = 1'b1;
    if1.in_data  = b;
    n = 0;
    while (!if1.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check("ready_timeout", 32'(if1.in_ready), 32'd1);
      if1.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if1.in_valid = 1'b0;
      model_byte(b);
    end
  endtask

  task automatic wait_idle(output int cnt);
    @(negedge clk);
    cnt = 0;
    while (busy1 && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic vsync_pulses(input int n);
    repeat (n) begin
      @(negedge clk); vsync2 = 1'b1;
      @(negedge clk); vsync2 = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [255:0] oh;
    reset_n = 1'b0;
    clear1 = 1'b0; clear2 = 1'b0; vsync1 = 1'b0; vsync2 = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0;
    if2.in_valid = 1'b0; if2.in_data = '0;
    char_x = '0; char_y = '0; ascii_char = '0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy1), 32'd1);
    check("rst_ready", 32'(if1.in_ready), 32'd0);
    reset_n = 1'b1;
    wait_idle(cnt);
    check("reset_clear_len", 32'(cnt), 32'd640);
    check("ready_after_clear", 32'(if1.in_ready), 32'd1);
    check("rst_col", 32'(col1), 32'd0);
    check("rst_row", 32'(row1), 32'd0);
    check("dut2_idle", 32'(busy2), 32'd0);
    oh = '0; oh[8'h20] = 1'b1;
    probe("blank_cell", 1'b0, 5, 3, oh, 1'b1);
    chk_cell(39, 15);

    send_byte(8'h48);
    send_byte(8'h49);
    check("hi_col", 32'(col1), 32'd2);
    chk_cell(0, 0);
    chk_cell(1, 0);
    send_byte(8'h01);
    check("ctrl_noeffect_col", 32'(col1), 32'd2);

    send_byte(8'h0D);
    repeat (40) send_byte(8'h41);
    check("wrap_col", 32'(col1), 32'd0);
    check("wrap_row", 32'(row1), 32'd1);
    chk_cell(39, 0);
    send_byte(8'h08);
    check("bs0_col", 32'(col1), 32'd0);
    check("bs0_row", 32'(row1), 32'd1);
    send_byte(8'h58);
    send_byte(8'h59);
    send_byte(8'h08);
    check("bs_col", 32'(col1), 32'd1);
    chk_cell(1, 1);
    chk_cell(0, 1);

    send_byte(8'h0D);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h42 + i));
    while (mrow < 15) send_byte(8'h0A);
    check("pre_scroll_row", 32'(row1), 32'd15);
    send_byte(8'h0A);
    wait_idle(cnt);
    check("scroll_len", 32'(cnt), 32'd640);
    check("scroll_row", 32'(row1), 32'd15);
    check("scroll_col", 32'(col1), 32'd0);
    for (int x = 0; x < 6; x++) chk_cell(x, 0);
    chk_cell(39, 0);
    chk_cell(0, 1);
    chk_cell(0, 15);
    chk_cell(39, 15);

    send_byte(8'h51);
    @(negedge clk);
    clear1 = 1'b1;
    if1.in_valid = 1'b1;
    if1.in_data = 8'h41;
    #1;
    check("clear_prio_ready", 32'(if1.in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear1 = 1'b0;
    if1.in_valid = 1'b0;
    model_clear();
    wait_idle(cnt);
    check("clear_len", 32'(cnt), 32'd640);
    check("clear_col", 32'(col1), 32'd0);
    check("clear_row", 32'(row1), 32'd0);
    chk_cell(0, 0);
    chk_cell(0, 15);

    send_byte(8'h5A);
    while (mrow < 15) send_byte(8'h0A);
    send_byte(8'h57);
    send_byte(8'h0A);
    repeat (100) @(negedge clk);
    check("mid_scroll_busy", 32'(busy1), 32'd1);
    clear1 = 1'b1;
    @(posedge clk);
    #1;
    clear1 = 1'b0;
    model_clear();
    wait_idle(cnt);
    check("abort_clear_len", 32'(cnt), 32'd640);
    check("abort_col", 32'(col1), 32'd0);
    check("abort_row", 32'(row1), 32'd0);
    chk_cell(0, 0);
    chk_cell(0, 14);
    chk_cell(5, 7);

    send_byte(8'h4B);
    send_byte(8'h0C);
    wait_idle(cnt);
    check("ff_len", 32'(cnt), 32'd640);
    check("ff_col", 32'(col1), 32'd0);
    chk_cell(0, 0);

    oh = '0; oh[8'h20] = 1'b1;
    probe("win_left", 1'b1, 9, 5, '1, 1'b0);
    probe("win_origin", 1'b1, 10, 5, oh, 1'b1);
    probe("win_br", 1'b1, 49, 20, '1, 1'b1);
    probe("win_right", 1'b1, 50, 5, '1, 1'b0);
    probe("win_top", 1'b1, 10, 4, '1, 1'b0);
    probe("win_bottom", 1'b1, 10, 21, '1, 1'b0);
    vsync_pulses(32);
    probe("cursor_on_blank", 1'b1, 10, 5, '0, 1'b1);
    probe("cursor_on_set", 1'b1, 10, 5, '1, 1'b0);
    probe("cursor_neighbor", 1'b1, 11, 5, '0, 1'b0);
    vsync_pulses(31);
    probe("cursor_still_on", 1'b1, 10, 5, '0, 1'b1);
    vsync_pulses(1);
    probe("cursor_off", 1'b1, 10, 5, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
